// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: on-chip history of per-stage PC/valid for the pipeline.
// Captures one entry per clock into a circular buffer while armed, stops a
// fixed number of cycles after a trigger, then streams entries oldest-first.
module pipe_trace_buffer #(
  parameter int NUM_STAGES = 5,
  parameter int PC_W       = 64,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 4,
  parameter int CYC_W      = 16
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_STAGES*PC_W-1:0]              stage_pc,
  input  logic [NUM_STAGES-1:0]                   stage_valid,
  input  logic                                    stall_in,
  input  logic                                    arm,
  input  logic [1:0]                              trig_mode,
  input  logic [PC_W-1:0]                         trig_pc,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [CYC_W+NUM_STAGES+NUM_STAGES*PC_W-1:0] out_data,
  output logic [1:0]                              state_o,
  output logic                                    wrapped
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = CYC_W + NUM_STAGES + NUM_STAGES * PC_W;

  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [AW-1:0]    POST_C  = AW'(POST_TRIG);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      post_cnt_q, post_cnt_d;
  logic [AW:0]        count_q, count_d;
  logic               wrapped_q, wrapped_d;
  logic [CYC_W-1:0]   cyc_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               trig;
  logic               capture;
  logic [AW-1:0]      rd_idx;

  // Trigger condition evaluated on this cycle's observed pipeline state
  always_comb begin
    trig = 1'b0;
    case (trig_mode)
      2'b00:   trig = 1'b1;
      2'b01:   trig = stage_valid[0] && (stage_pc[PC_W-1:0] == trig_pc);
      2'b10:   trig = stall_in;
      default: trig = stage_valid[NUM_STAGES-1] &&
                      (stage_pc[(NUM_STAGES-1)*PC_W +: PC_W] == trig_pc);
    endcase
  end

  // Next-state logic: capture bookkeeping, trigger/post countdown, drain pops
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    wrapped_d  = wrapped_q;
    capture    = (state_q == S_ARMED) || (state_q == S_POST);

    // Every capturing cycle advances the write pointer; a full buffer
    // keeps its count and records that history was overwritten.
    if (capture) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q == DEPTH_C) begin
        wrapped_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_ARMED;
          count_d   = '0;
          wrapped_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (trig) begin
          post_cnt_d = POST_C;
          state_d    = (POST_TRIG == 0) ? S_DRAIN : S_POST;
        end
      end
      S_POST: begin
        post_cnt_d = post_cnt_q - PTR_ONE;
        if (post_cnt_q == PTR_ONE) begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        // Empty drain cannot normally occur; fall back to idle defensively.
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  // State registers and the free-running cycle stamp
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      wrapped_q  <= 1'b0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      wrapped_q  <= wrapped_d;
      cyc_q      <= cyc_q + CYC_ONE;
    end
  end

  // Trace storage write port; contents need no reset since count gates reads
  always_ff @(posedge clock) begin
    if (capture && !reset) begin
      mem_q[wr_ptr_q] <= {cyc_q, stage_valid, stage_pc};
    end
  end

  // Oldest entry sits count positions behind the write pointer. The read is
  // combinational so the head is presented on the first DRAIN cycle even when
  // it was written on the final capture edge.
  assign rd_idx    = wr_ptr_q - count_q[AW-1:0];
  assign out_data  = mem_q[rd_idx];
  assign out_valid = (state_q == S_DRAIN) && (count_q != '0);
  assign state_o   = state_q;
  assign wrapped   = wrapped_q;

endmodule
